watchdog_pat_sequencer: RTL
===========================

WATCHDOG_PAT_SEQUENCER -- requirements
Module: watchdog_pat_sequencer

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of heartbeat requesters.
REQ-002 SHALL have parameter PAT_GAP, default 8'd16: minimum cycles between successive pats.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_start  input  1  one-cycle request to (re)configure and arm the watchdog.
REQ-006 SHALL have port cfg_open  input  32  window-open value, captured when cfg_start is accepted.
REQ-007 SHALL have port cfg_close  input  32  window-close value, captured when cfg_start is accepted.
REQ-008 SHALL have port hb_req  input  N_REQ  per-requester heartbeat pulse.
REQ-009 SHALL have port hb_mask  input  N_REQ  participating requesters.
REQ-010 SHALL have port wd_expired  input  1  watchdog user_interrupt.
REQ-011 SHALL have port wd_address  output  6  watchdog register address.
REQ-012 SHALL have port wd_data  output  32  watchdog write data.
REQ-013 SHALL have port wd_write_n  output  2  watchdog write strobe: 2'b10 = 32-bit write, 2'b11 = idle.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE, RUN or FAULT.
REQ-015 SHALL have port fault  output  1  high in state FAULT.
REQ-016 SHALL have port missing  output  N_REQ  masked requesters that had not checked in at fault time.
REQ-017 SHALL have port pat_count  output  16  pats issued since the last accepted cfg_start.

Function
REQ-018 SHALL implement states IDLE, DIS, WOPEN, WCLOSE, EN, RUN, PAT and FAULT.
REQ-019 SHALL accept cfg_start in IDLE, RUN or FAULT by entering DIS on the next edge, capturing cfg_open/cfg_close and clearing seen, gap and pat_count.
REQ-020 SHALL ignore cfg_start in DIS, WOPEN, WCLOSE, EN and PAT.
REQ-021 SHALL drive one write per cycle, decoded from the registered state: DIS addr 0 data 0, WOPEN addr 1 data cfg_open, WCLOSE addr 2 data cfg_close, EN addr 0 data 1, PAT addr 3 data 1.
REQ-022 SHALL step DIS->WOPEN->WCLOSE->EN->RUN unconditionally, one cycle each; DIS comes first because the watchdog ignores window writes while enabled.
REQ-023 SHALL drive wd_write_n=2'b11, wd_address=0 and wd_data=0 in every non-write state.
REQ-024 SHALL in RUN, each cycle, update seen <= seen | (hb_req & hb_mask).
REQ-025 SHALL in RUN maintain gap as an 8-bit counter that increments each cycle and saturates at 255.
REQ-026 SHALL go RUN->PAT when hb_mask != 0, ((seen | hb_req) & hb_mask) == hb_mask and gap >= PAT_GAP.
REQ-027 SHALL in PAT write for exactly one cycle, set seen <= hb_req & hb_mask, clear gap, increment pat_count saturating at 16'hFFFF, then return to RUN.
REQ-028 SHALL, when hb_mask == 0, never pat.
REQ-029 SHALL, when wd_expired is high in RUN or PAT, go to FAULT and latch missing <= hb_mask & ~seen; a PAT write in that cycle still completes.
REQ-030 SHALL hold FAULT, which is sticky, until cfg_start; wd_expired in other states is ignored.
REQ-031 SHALL give cfg_start priority over wd_expired and over the pat condition when both occur in RUN.

Reset
REQ-032 SHALL on rst, asynchronously, set state IDLE, seen 0, gap 0, pat_count 0, missing 0 and the captured windows 0.
REQ-033 SHALL during and after reset drive wd_write_n=2'b11, busy=0 and fault=0.
REQ-034 SHALL on rst mid-sequence abandon the sequence with no further writes.

Structure
REQ-035 SHALL place in package watchdog_seq_pkg: the state enum, ADDR_ENABLE=6'h0, ADDR_OPEN=6'h1, ADDR_CLOSE=6'h2, ADDR_PAT=6'h3, WR_32=2'b10 and WR_NONE=2'b11.
REQ-036 SHALL implement the seen/gap tracking as one sub-module, watchdog_hb_collector (inputs: clear, load, hb_req, hb_mask; outputs: seen, all_seen, gap).

Verification
REQ-037 SHALL cover: cfg_start with open=100, close=200 -> four cycles of writes (0/0, 1/100, 2/200, 0/1), busy=1, then RUN with busy=0.
REQ-038 SHALL cover: mask=4'b0011, hb on bits 0 then 1, gap>=16 -> single addr-3 write, pat_count=1, seen cleared.
REQ-039 SHALL cover: mask=4'b0011, all hb at gap=5 -> pat delayed until gap=16.
REQ-040 SHALL cover: mask=4'b0111, only bit 0 seen, wd_expired=1 -> FAULT, missing=4'b0110, no further writes; cfg_start -> reconfigure sequence, pat_count=0.
REQ-041 SHALL cover: hb_req=4'b0001 in PAT cycle with mask=4'b0001 -> counted into next round, next pat at gap=16.
REQ-042 SHALL cover: rst asserted during WOPEN -> wd_write_n=2'b11 immediately, state IDLE, pat_count=0.

Source files
------------

// File: rtl/watchdog_seq_pkg.sv
// Shared state encoding, watchdog register map and write-strobe codes.
package watchdog_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIS    = 3'd1,
        ST_WOPEN  = 3'd2,
        ST_WCLOSE = 3'd3,
        ST_EN     = 3'd4,
        ST_RUN    = 3'd5,
        ST_PAT    = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] ADDR_ENABLE = 6'h0;
    localparam logic [5:0] ADDR_OPEN   = 6'h1;
    localparam logic [5:0] ADDR_CLOSE  = 6'h2;
    localparam logic [5:0] ADDR_PAT    = 6'h3;

    localparam logic [1:0] WR_32   = 2'b10;
    localparam logic [1:0] WR_NONE = 2'b11;

    // Busy covers the states that are part of a write sequence.
    function automatic logic is_busy(input state_t s);
        return !(s == ST_IDLE || s == ST_RUN || s == ST_FAULT);
    endfunction

endpackage

// File: rtl/watchdog_hb_collector.sv
// Tracks which masked requesters have checked in since the last pat and
// how many cycles have elapsed in RUN since then.
module watchdog_hb_collector #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             run,
    input  logic [N_REQ-1:0] hb_req,
    input  logic [N_REQ-1:0] hb_mask,
    output logic [N_REQ-1:0] seen,
    output logic             all_seen,
    output logic [7:0]       gap
);

    logic [N_REQ-1:0] r_seen;
    logic [7:0]       r_gap;
    logic [N_REQ-1:0] w_hb;

    assign w_hb = hb_req & hb_mask;

    // Clear wins over load; a heartbeat arriving on the pat cycle seeds the next round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen <= '0;
            r_gap  <= '0;
        end else if (clear) begin
            r_seen <= '0;
            r_gap  <= '0;
        end else if (load) begin
            r_seen <= w_hb;
            r_gap  <= '0;
        end else if (run) begin
            r_seen <= r_seen | w_hb;
            if (r_gap != 8'hFF) begin
                r_gap <= r_gap + 8'd1;
            end
        end
    end

    // Same-cycle heartbeats count toward completeness; an empty mask never completes.
    always_comb begin
        all_seen = (hb_mask != '0) && (((r_seen | hb_req) & hb_mask) == hb_mask);
    end

    assign seen = r_seen;
    assign gap  = r_gap;

endmodule

// File: rtl/watchdog_pat_sequencer.sv
// Programs a windowed watchdog (disable, open, close, enable) and then pats it
// once every masked requester has checked in and the minimum gap has elapsed.
//
// cfg_start is a single-cycle request with no ready: it is accepted only in
// IDLE, RUN or FAULT (taking priority over expiry and pat there) and dropped
// silently in any other state.
module watchdog_pat_sequencer
    import watchdog_seq_pkg::*;
#(
    parameter int         N_REQ   = 4,
    parameter logic [7:0] PAT_GAP = 8'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_open,
    input  logic [31:0]      cfg_close,
    input  logic [N_REQ-1:0] hb_req,
    input  logic [N_REQ-1:0] hb_mask,
    input  logic             wd_expired,
    output logic [5:0]       wd_address,
    output logic [31:0]      wd_data,
    output logic [1:0]       wd_write_n,
    output logic             busy,
    output logic             fault,
    output logic [N_REQ-1:0] missing,
    output logic [15:0]      pat_count,
    output state_t           dbg_state
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic [31:0]      r_cfg_open;
    logic [31:0]      r_cfg_close;
    logic [15:0]      r_pat_count;
    logic [N_REQ-1:0] r_missing;
    logic [N_REQ-1:0] w_seen;
    logic             w_all_seen;
    logic [7:0]       w_gap;

    watchdog_hb_collector #(.N_REQ(N_REQ)) u_collector (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_accept),
        .load     (r_state == ST_PAT),
        .run      (r_state == ST_RUN),
        .hb_req   (hb_req),
        .hb_mask  (hb_mask),
        .seen     (w_seen),
        .all_seen (w_all_seen),
        .gap      (w_gap)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: configuration sequence steps unconditionally; RUN arbitrates
    // cfg_start > expiry > pat.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE, ST_FAULT: begin
                if (cfg_start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_DIS;
                end
            end
            ST_DIS:    w_state_next = ST_WOPEN;
            ST_WOPEN:  w_state_next = ST_WCLOSE;
            ST_WCLOSE: w_state_next = ST_EN;
            ST_EN:     w_state_next = ST_RUN;
            ST_RUN: begin
                if (cfg_start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_DIS;
                end else if (wd_expired) begin
                    w_state_next = ST_FAULT;
                end else if (w_all_seen && (w_gap >= PAT_GAP)) begin
                    w_state_next = ST_PAT;
                end
            end
            ST_PAT: begin
                w_state_next = wd_expired ? ST_FAULT : ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Watchdog write bus decoded from the registered state only.
    always_comb begin
        wd_write_n = WR_NONE;
        wd_address = ADDR_ENABLE;
        wd_data    = 32'd0;
        case (r_state)
            ST_DIS: begin
                wd_write_n = WR_32;
                wd_address = ADDR_ENABLE;
                wd_data    = 32'd0;
            end
            ST_WOPEN: begin
                wd_write_n = WR_32;
                wd_address = ADDR_OPEN;
                wd_data    = r_cfg_open;
            end
            ST_WCLOSE: begin
                wd_write_n = WR_32;
                wd_address = ADDR_CLOSE;
                wd_data    = r_cfg_close;
            end
            ST_EN: begin
                wd_write_n = WR_32;
                wd_address = ADDR_ENABLE;
                wd_data    = 32'd1;
            end
            ST_PAT: begin
                wd_write_n = WR_32;
                wd_address = ADDR_PAT;
                wd_data    = 32'd1;
            end
            default: ;
        endcase
    end

    // Window capture, pat counting and the fault snapshot of missing requesters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_open  <= '0;
            r_cfg_close <= '0;
            r_pat_count <= '0;
            r_missing   <= '0;
        end else begin
            if (w_accept) begin
                r_cfg_open  <= cfg_open;
                r_cfg_close <= cfg_close;
                r_pat_count <= '0;
            end else if (r_state == ST_PAT && r_pat_count != 16'hFFFF) begin
                r_pat_count <= r_pat_count + 16'd1;
            end
            if (r_state != ST_FAULT && w_state_next == ST_FAULT) begin
                r_missing <= hb_mask & ~w_seen;
            end
        end
    end

    assign busy      = is_busy(r_state);
    assign fault     = (r_state == ST_FAULT);
    assign missing   = r_missing;
    assign pat_count = r_pat_count;
    assign dbg_state = r_state;

endmodule
